cmp_scheduler: RTL and testbench
================================

Name: cmp_scheduler

Overview:
- Shares the single 32-bit datapath comparator between two requesters: branch resolution (requester 0) and set-on-compare (requester 1).
- Arbitrates round-robin, registers the operands, drives the comparator, captures its 1-bit result and returns it to the owning requester over a valid/ready response channel.
- Sits between the requesters and the comparator instance; the comparator itself stays a separate, purely combinational instance.

Parameters:
WIDTH, 32, operand width (must match comparator)
OPW, 3, op-code width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
r0_valid  in  1  requester 0 has a compare pending
r0_ready  out  1  requester 0 request accepted this cycle
r0_a  in  WIDTH  requester 0 operand a
r0_b  in  WIDTH  requester 0 operand b
r0_op  in  OPW  requester 0 compare op
r0_rsp_valid  out  1  requester 0 result available
r0_rsp_result  out  1  requester 0 compare result
r0_rsp_ready  in  1  requester 0 consumes result
r1_valid, r1_ready, r1_a, r1_b, r1_op, r1_rsp_valid, r1_rsp_result, r1_rsp_ready: identical for requester 1
cmp_a  out  WIDTH  to comparator operand a
cmp_b  out  WIDTH  to comparator operand b
cmp_op  out  OPW  to comparator op
cmp_result  in  1  from comparator
busy  out  1  state != IDLE
last_grant  out  1  id of most recently accepted requester

Behaviour:
- Op encoding: 000 eq, 001 ge (unsigned), 010 le, 011 gt, 100 lt, 101 ne, 110/111 undefined.
  - Undefined ops are passed through unchanged; the comparator returns 0 and the result is delivered as 0, no error.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner selection: only one rX_valid high -> that requester wins. Both high -> the requester != last_grant wins.
  - rX_ready = (state==IDLE) && winner==X, combinational. At most one ready high; none when neither valid.
  - On valid&ready: latch a/b/op into the operand registers, owner<=X, last_grant<=X, go to EXEC.
- EXEC (1 cycle): cmp_a/cmp_b/cmp_op come straight from the operand registers, so they are stable all cycle. On the clock edge, result_reg<=cmp_result and the FSM goes to RESP.
- RESP:
  - r{owner}_rsp_valid=1 and r{owner}_rsp_result=result_reg, both held stable until r{owner}_rsp_ready=1; then go to IDLE.
  - The other requester's rsp_valid stays 0.
  - No new request is accepted in RESP. The earliest next ready is the cycle after the response handshake.
- Latency: accept edge N -> result captured edge N+1 -> rsp_valid high during cycle N+2. With rsp_ready held high, minimum issue interval is 3 cycles.
- rsp_ready while rsp_valid=0 is ignored.
- rX_valid dropped before acceptance: no effect; arbitration is re-evaluated every IDLE cycle.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…
- Reset (reset=0, asynchronous):
  - state=IDLE; operand registers, result_reg, owner = 0; last_grant=1, so requester 0 wins the first tie.
  - All rsp_valid=0, busy=0; cmp_a=cmp_b=0, cmp_op=000.
  - A reset mid-operation discards the pending compare; no response is issued after reset release.
- busy = (state != IDLE), derived from state regs only.

Decomposition:
- Package cmp_sched_pkg holds: op constants CMP_EQ..CMP_NE, state typedef {IDLE, EXEC, RESP}, WIDTH/OPW defaults.
- One sub-module, rr_arb2: 2-way round-robin pick, with inputs req[1:0] and last and outputs gnt[1:0] and gnt_id.
- Operand/result registers and the FSM stay in cmp_scheduler.

Test Plan:
- Reset release, no requests -> all ready/rsp_valid=0, busy=0, last_grant=1, cmp_op=000.
- r0 only: a=5, b=5, op=000, rsp_ready=1 -> r0_ready in cycle 0, cmp_a/cmp_b=5 in cycle 1, r0_rsp_valid=1 with result=1 in cycle 2, back to IDLE in cycle 3.
- Both valid continuously: r0 a=3, b=7, op=100 (lt); r1 a=3, b=7, op=011 (gt) -> grants 0,1,0,1 alternating; r0 results 1, r1 results 0.
- Response backpressure: r1 a=9, b=2, op=001, rsp_ready held low 5 cycles -> rsp_valid and result=1 held stable; r0_ready=0 throughout; release -> IDLE next cycle.
- Undefined op: r0 op=111, a=b=0 -> response delivered with result=0, no hang.
- Reset mid-EXEC after accepting r1 -> after release, no rsp_valid for r1; the next tie grants r0.

Source files
------------

// File: rtl/cmp_sched_pkg.sv
// rtl/cmp_sched_pkg.sv - shared constants and state type for the comparator scheduler
package cmp_sched_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int OPW_DEF   = 3;

  localparam logic [2:0] CMP_EQ = 3'b000;
  localparam logic [2:0] CMP_GE = 3'b001;
  localparam logic [2:0] CMP_LE = 3'b010;
  localparam logic [2:0] CMP_GT = 3'b011;
  localparam logic [2:0] CMP_LT = 3'b100;
  localparam logic [2:0] CMP_NE = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick; on a tie the requester that did not win last goes
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    case (req)
      2'b01: begin gnt = 2'b01; gnt_id = 1'b0; end
      2'b10: begin gnt = 2'b10; gnt_id = 1'b1; end
      2'b11: begin
        gnt_id = ~last;
        gnt    = last ? 2'b01 : 2'b10;
      end
      default: begin gnt = 2'b00; gnt_id = 1'b0; end
    endcase
  end

endmodule

// File: rtl/cmp_scheduler.sv
// rtl/cmp_scheduler.sv - shares one combinational comparator between two requesters
module cmp_scheduler
  import cmp_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [OPW-1:0]   r0_op,
  output logic             r0_rsp_valid,
  output logic             r0_rsp_result,
  input  logic             r0_rsp_ready,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [OPW-1:0]   r1_op,
  output logic             r1_rsp_valid,
  output logic             r1_rsp_result,
  input  logic             r1_rsp_ready,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  output logic [OPW-1:0]   cmp_op,
  input  logic             cmp_result,
  output logic             busy,
  output logic             last_grant
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             res_q, res_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [1:0]       gnt;
  logic             gnt_id;
  logic             owner_rsp_ready;

  rr_arb2 u_arb (
    .req    ({r1_valid, r0_valid}),
    .last   (last_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign owner_rsp_ready = owner_q ? r1_rsp_ready : r0_rsp_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          state_d = EXEC;
          owner_d = gnt_id;
          last_d  = gnt_id;
          a_d     = gnt_id ? r1_a  : r0_a;
          b_d     = gnt_id ? r1_b  : r0_b;
          op_d    = gnt_id ? r1_op : r0_op;
        end
      end
      EXEC: begin
        res_d   = cmp_result;
        state_d = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // last_grant resets to 1 so requester 0 takes the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign r0_ready      = (state_q == IDLE) && gnt[0];
  assign r1_ready      = (state_q == IDLE) && gnt[1];
  assign r0_rsp_valid  = (state_q == RESP) && !owner_q;
  assign r1_rsp_valid  = (state_q == RESP) &&  owner_q;
  assign r0_rsp_result = r0_rsp_valid & res_q;
  assign r1_rsp_result = r1_rsp_valid & res_q;
  assign cmp_a         = a_q;
  assign cmp_b         = b_q;
  assign cmp_op        = op_q;
  assign busy          = (state_q != IDLE);
  assign last_grant    = last_q;

endmodule

// File: tb/tb_cmp_scheduler.sv
// tb/tb_cmp_scheduler.sv - self-checking bench for cmp_scheduler with a behavioural comparator
module tb_cmp_scheduler;

  logic        clock;
  logic        reset;
  logic        r0_valid, r0_ready, r0_rsp_valid, r0_rsp_result, r0_rsp_ready;
  logic [31:0] r0_a, r0_b;
  logic [2:0]  r0_op;
  logic        r1_valid, r1_ready, r1_rsp_valid, r1_rsp_result, r1_rsp_ready;
  logic [31:0] r1_a, r1_b;
  logic [2:0]  r1_op;
  logic [31:0] cmp_a, cmp_b;
  logic [2:0]  cmp_op;
  logic        cmp_result;
  logic        busy, last_grant;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic ref_cmp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a == b;
      3'd1: return a >= b;
      3'd2: return a <= b;
      3'd3: return a > b;
      3'd4: return a < b;
      3'd5: return a != b;
      default: return 1'b0;
    endcase
  endfunction

  assign cmp_result = ref_cmp(cmp_a, cmp_b, cmp_op);

  cmp_scheduler #(.WIDTH(32), .OPW(3)) dut (
    .clock(clock), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_result(r0_rsp_result), .r0_rsp_ready(r0_rsp_ready),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_result(r1_rsp_result), .r1_rsp_ready(r1_rsp_ready),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_op(cmp_op), .cmp_result(cmp_result),
    .busy(busy), .last_grant(last_grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({r1_ready, r0_ready, r1_rsp_valid, r0_rsp_valid, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b want 00000", {r1_ready, r0_ready, r1_rsp_valid, r0_rsp_valid, busy});
    end
    n_cmp++;
    if (last_grant !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_last_grant: got %b want 1", last_grant);
    end
    n_cmp++;
    if ({cmp_op, cmp_a, cmp_b} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_cmp_bus: op=%b a=%0d b=%0d want all 0", cmp_op, cmp_a, cmp_b);
    end
  endtask

  task automatic test_single();
    @(negedge clock);
    r0_valid = 1'b1; r0_a = 5; r0_b = 5; r0_op = 3'b000;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if ({r1_ready, r0_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 01", {r1_ready, r0_ready});
    end
    @(negedge clock);
    r0_valid = 1'b0;
    #1;
    n_cmp++;
    if ({busy, r0_rsp_valid} !== 2'b10 || cmp_a !== 32'd5 || cmp_b !== 32'd5) begin
      n_fail++;
      $display("FAIL single_exec: busy=%b rsp=%b a=%0d b=%0d want 1 0 5 5", busy, r0_rsp_valid, cmp_a, cmp_b);
    end
    @(negedge clock);
    #1;
    n_cmp++;
    if ({r1_rsp_valid, r0_rsp_valid, r0_rsp_result} !== 3'b011) begin
      n_fail++;
      $display("FAIL single_resp: got %b want 011", {r1_rsp_valid, r0_rsp_valid, r0_rsp_result});
    end
    @(negedge clock);
    #1;
    n_cmp++;
    if ({busy, last_grant} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_done: busy/last got %b want 00", {busy, last_grant});
    end
  endtask

  task automatic test_alternate();
    int waits;
    apply_reset();
    @(negedge clock);
    r0_valid = 1'b1; r0_a = 3; r0_b = 7; r0_op = 3'b100;
    r1_valid = 1'b1; r1_a = 3; r1_b = 7; r1_op = 3'b011;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic exp_id;
      exp_id = k[0];
      waits = 0;
      if (k == 0) #1;
      while (!(r0_ready || r1_ready) && waits < 10) begin
        @(negedge clock); #1; waits++;
      end
      n_cmp++;
      if ({r1_ready, r0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL alt_grant%0d: got %b want %b", k, {r1_ready, r0_ready}, exp_id ? 2'b10 : 2'b01);
      end
      if (k > 0) begin
        n_cmp++;
        if (waits !== 1) begin
          n_fail++;
          $display("FAIL alt_interval%0d: got %0d cycles after response want 1", k, waits);
        end
      end
      waits = 0;
      do begin
        @(negedge clock); #1; waits++;
      end while (!(r0_rsp_valid || r1_rsp_valid) && waits < 10);
      n_cmp++;
      if (waits !== 2 || {r1_rsp_valid, r0_rsp_valid} !== (exp_id ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL alt_rsp%0d: latency=%0d valid=%b want 2 %b", k, waits, {r1_rsp_valid, r0_rsp_valid}, exp_id ? 2'b10 : 2'b01);
      end
      n_cmp++;
      if ((exp_id ? r1_rsp_result : r0_rsp_result) !== (exp_id ? 1'b0 : 1'b1)) begin
        n_fail++;
        $display("FAIL alt_result%0d: got %b want %b", k, exp_id ? r1_rsp_result : r0_rsp_result, !exp_id);
      end
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    @(negedge clock);
    r1_valid = 1'b1; r1_a = 9; r1_b = 2; r1_op = 3'b001; r1_rsp_ready = 1'b0;
    #1;
    n_cmp++;
    if ({r1_ready, r0_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_accept: got %b want 10", {r1_ready, r0_ready});
    end
    @(negedge clock);
    r1_valid = 1'b0;
    r0_valid = 1'b1; r0_a = 1; r0_b = 1; r0_op = 3'b000;
    #1;
    n_cmp++;
    if (r0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_exec_ready: got %b want 0", r0_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 5) r1_rsp_ready = 1'b1;
      #1;
      n_cmp++;
      if ({r1_rsp_valid, r1_rsp_result, r0_ready, r0_rsp_valid} !== 4'b1100) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got %b want 1100", i, {r1_rsp_valid, r1_rsp_result, r0_ready, r0_rsp_valid});
      end
    end
    @(negedge clock);
    #1;
    n_cmp++;
    if ({busy, r1_rsp_valid, r0_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL bp_release: busy/rsp/r0_ready got %b want 001", {busy, r1_rsp_valid, r0_ready});
    end
    r0_valid = 1'b0;
    @(negedge clock);
    #1;
    n_cmp++;
    if ({busy, last_grant} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_drop: busy/last got %b want 01", {busy, last_grant});
    end
  endtask

  task automatic test_undef();
    int waits;
    @(negedge clock);
    r0_valid = 1'b1; r0_a = 0; r0_b = 0; r0_op = 3'b111; r0_rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (r0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL undef_accept: got %b want 1", r0_ready);
    end
    @(negedge clock);
    r0_valid = 1'b0;
    #1;
    n_cmp++;
    if (cmp_op !== 3'b111) begin
      n_fail++;
      $display("FAIL undef_passthru: cmp_op got %b want 111", cmp_op);
    end
    waits = 0;
    do begin
      @(negedge clock); #1; waits++;
    end while (!r0_rsp_valid && waits < 8);
    n_cmp++;
    if ({r0_rsp_valid, r0_rsp_result} !== 2'b10) begin
      n_fail++;
      $display("FAIL undef_rsp: valid/result got %b want 10", {r0_rsp_valid, r0_rsp_result});
    end
    @(negedge clock);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL undef_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    r1_valid = 1'b1; r1_a = 4; r1_b = 4; r1_op = 3'b000; r1_rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (r1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_accept: got %b want 1", r1_ready);
    end
    @(negedge clock);
    r1_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, last_grant} !== 2'b01 || cmp_a !== 32'd0) begin
      n_fail++;
      $display("FAIL rmid_async: busy/last got %b cmp_a=%0d want 01 0", {busy, last_grant}, cmp_a);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      #1;
      n_cmp++;
      if ({r1_rsp_valid, r0_rsp_valid, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL rmid_norsp%0d: got %b want 000", i, {r1_rsp_valid, r0_rsp_valid, busy});
      end
    end
    @(negedge clock);
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    n_cmp++;
    if ({r1_ready, r0_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rmid_tie: got %b want 01", {r1_ready, r0_ready});
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
  endtask

  task automatic test_random();
    logic       m_last, pending, pend_id, pend_res;
    int         age;
    logic [1:0] exp_rdy, exp_rv;
    apply_reset();
    m_last = 1'b1; pending = 1'b0; pend_id = 1'b0; pend_res = 1'b0; age = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clock);
      r0_valid = ($urandom_range(0, 2) != 0);
      r1_valid = ($urandom_range(0, 2) != 0);
      r0_a = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      r0_b = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      r1_a = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      r1_b = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      r0_op = 3'($urandom_range(0, 7));
      r1_op = 3'($urandom_range(0, 7));
      r0_rsp_ready = $urandom_range(0, 1) != 0;
      r1_rsp_ready = $urandom_range(0, 1) != 0;
      #1;
      exp_rdy = 2'b00;
      if (!pending) begin
        if (r0_valid && r1_valid) exp_rdy = m_last ? 2'b01 : 2'b10;
        else exp_rdy = {r1_valid, r0_valid};
      end
      exp_rv = (pending && age >= 2) ? (pend_id ? 2'b10 : 2'b01) : 2'b00;
      n_cmp++;
      if ({r1_ready, r0_ready} !== exp_rdy) begin
        n_fail++;
        $display("FAIL rand_ready@%0d: got %b want %b", cyc, {r1_ready, r0_ready}, exp_rdy);
      end
      n_cmp++;
      if ({r1_rsp_valid, r0_rsp_valid} !== exp_rv) begin
        n_fail++;
        $display("FAIL rand_rsp_valid@%0d: got %b want %b", cyc, {r1_rsp_valid, r0_rsp_valid}, exp_rv);
      end
      if (exp_rv != 2'b00) begin
        n_cmp++;
        if ((pend_id ? r1_rsp_result : r0_rsp_result) !== pend_res) begin
          n_fail++;
          $display("FAIL rand_result@%0d: got %b want %b", cyc, pend_id ? r1_rsp_result : r0_rsp_result, pend_res);
        end
      end
      if (exp_rv != 2'b00 && (pend_id ? r1_rsp_ready : r0_rsp_ready)) pending = 1'b0;
      else if (pending) age++;
      if (exp_rdy != 2'b00) begin
        pending  = 1'b1;
        age      = 1;
        pend_id  = exp_rdy[1];
        pend_res = pend_id ? ref_cmp(r1_a, r1_b, r1_op) : ref_cmp(r0_a, r0_b, r0_op);
        m_last   = pend_id;
      end
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    reset = 1'b0;
    r0_valid = 1'b0; r0_a = '0; r0_b = '0; r0_op = '0; r0_rsp_ready = 1'b0;
    r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_op = '0; r1_rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_undef();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
